// File: rtl/pound_lock_if.sv
// Request and status bundle between the board top level and the pound lock controller.
interface pound_lock_if #(
  parameter int unsigned LEVEL_W = 8
) ();
  logic               arrive_req;
  logic               depart_req;
  logic               boat_pass;
  logic [LEVEL_W-1:0] level;
  logic               gate_l_open;
  logic               gate_r_open;
  logic               filling;
  logic               draining;
  logic               in_chamber;
  logic               left_good;
  logic               right_good;
  logic               pend_arr;
  logic               pend_dep;
  logic               busy;
  logic               err;

  modport master (
    output arrive_req, depart_req, boat_pass,
    input  level, gate_l_open, gate_r_open, filling, draining, in_chamber,
           left_good, right_good, pend_arr, pend_dep, busy, err
  );

  modport slave (
    input  arrive_req, depart_req, boat_pass,
    output level, gate_l_open, gate_r_open, filling, draining, in_chamber,
           left_good, right_good, pend_arr, pend_dep, busy, err
  );
endinterface

// File: rtl/pound_lock_ctrl.sv
// Self-sequencing pound lock chamber controller: queues passages, steps the
// chamber level and interlocks both gates against it.
module pound_lock_ctrl #(
  parameter int unsigned LEVEL_W      = 8,
  parameter int unsigned LOW_LEVEL    = 0,
  parameter int unsigned HIGH_LEVEL   = 100,
  parameter int unsigned STEP_CYCLES  = 4,
  parameter int unsigned GATE_CYCLES  = 2,
  parameter int unsigned OPEN_TIMEOUT = 16
) (
  input logic         clk,
  input logic         reset,
  pound_lock_if.slave bus
);
  localparam int unsigned CNT_MAX = (OPEN_TIMEOUT > GATE_CYCLES) ?
      ((OPEN_TIMEOUT > STEP_CYCLES) ? OPEN_TIMEOUT : STEP_CYCLES) :
      ((GATE_CYCLES  > STEP_CYCLES) ? GATE_CYCLES  : STEP_CYCLES);
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [LEVEL_W-1:0] LVL_LO    = LEVEL_W'(LOW_LEVEL);
  localparam logic [LEVEL_W-1:0] LVL_HI    = LEVEL_W'(HIGH_LEVEL);
  localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   OPEN_LAST = CNT_W'(OPEN_TIMEOUT - 1);
  localparam logic               DIR_UP    = 1'b0;
  localparam logic               DIR_DN    = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_FILL, S_OPEN_IN, S_CLOSE_IN, S_OPEN_OUT, S_CLOSE_OUT
  } state_t;

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic               abort_q, abort_d;
  logic               in_chamber_q, in_chamber_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_arr_q, pend_arr_d;
  logic               pend_dep_q, pend_dep_d;
  logic               err_q, err_d;
  logic               gate_l_q, gate_l_d;
  logic               gate_r_q, gate_r_d;
  logic               filling_q, filling_d;
  logic               draining_q, draining_d;
  logic               busy_q, busy_d;
  logic               left_good_q, left_good_d;
  logic               right_good_q, right_good_d;
  logic               clr_arr, clr_dep;
  logic               want_up, want_dn, open_st;
  logic [LEVEL_W-1:0] level_inc, level_dec;

  // Latched requests plus the one sampled on this edge take part in selection.
  assign want_up   = pend_arr_q | bus.arrive_req;
  assign want_dn   = pend_dep_q | bus.depart_req;
  assign open_st   = (state_q == S_OPEN_IN) || (state_q == S_OPEN_OUT);
  assign level_inc = level_q + LEVEL_W'(1);
  assign level_dec = level_q - LEVEL_W'(1);

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      dir_q        <= DIR_UP;
      abort_q      <= 1'b0;
      in_chamber_q <= 1'b0;
      level_q      <= LVL_LO;
      cnt_q        <= '0;
      pend_arr_q   <= 1'b0;
      pend_dep_q   <= 1'b0;
      err_q        <= 1'b0;
      gate_l_q     <= 1'b0;
      gate_r_q     <= 1'b0;
      filling_q    <= 1'b0;
      draining_q   <= 1'b0;
      busy_q       <= 1'b0;
      left_good_q  <= 1'b1;
      right_good_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      abort_q      <= abort_d;
      in_chamber_q <= in_chamber_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      pend_arr_q   <= pend_arr_d;
      pend_dep_q   <= pend_dep_d;
      err_q        <= err_d;
      gate_l_q     <= gate_l_d;
      gate_r_q     <= gate_r_d;
      filling_q    <= filling_d;
      draining_q   <= draining_d;
      busy_q       <= busy_d;
      left_good_q  <= left_good_d;
      right_good_q <= right_good_d;
    end
  end

  // Next-state, level stepping, request queue and error tracking.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    abort_d      = abort_q;
    in_chamber_d = in_chamber_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    clr_arr      = 1'b0;
    clr_dep      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (want_dn && level_q == LVL_HI) begin
          dir_d   = DIR_DN;
          state_d = S_OPEN_IN;
        end else if (want_up) begin
          dir_d   = DIR_UP;
          state_d = (level_q == LVL_LO) ? S_OPEN_IN : S_DRAIN;
        end else if (want_dn) begin
          dir_d   = DIR_DN;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d   = '0;
          level_d = level_inc;
          if (level_inc == LVL_HI) state_d = in_chamber_q ? S_OPEN_OUT : S_OPEN_IN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d   = '0;
          level_d = level_dec;
          if (level_dec == LVL_LO) state_d = in_chamber_q ? S_OPEN_OUT : S_OPEN_IN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OPEN_IN: begin
        // A boat crossing on the timeout edge still counts as an entry.
        if (bus.boat_pass) begin
          in_chamber_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_CLOSE_IN;
        end else if (OPEN_TIMEOUT != 0) begin
          if (cnt_q == OPEN_LAST) begin
            abort_d = 1'b1;
            clr_arr = (dir_q == DIR_UP);
            clr_dep = (dir_q == DIR_DN);
            cnt_d   = '0;
            state_d = S_CLOSE_IN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CLOSE_IN: begin
        if (cnt_q == GATE_LAST) begin
          cnt_d = '0;
          if (abort_q)               state_d = S_IDLE;
          else if (dir_q == DIR_UP)  state_d = S_FILL;
          else                       state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OPEN_OUT: begin
        if (bus.boat_pass) begin
          in_chamber_d = 1'b0;
          clr_arr      = (dir_q == DIR_UP);
          clr_dep      = (dir_q == DIR_DN);
          cnt_d        = '0;
          state_d      = S_CLOSE_OUT;
        end
      end
      S_CLOSE_OUT: begin
        if (cnt_q == GATE_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    pend_arr_d = (pend_arr_q & ~clr_arr) | bus.arrive_req;
    pend_dep_d = (pend_dep_q & ~clr_dep) | bus.depart_req;
    err_d      = err_q
               | (bus.boat_pass & ~open_st)
               | (open_st & ((bus.arrive_req & pend_arr_q) | (bus.depart_req & pend_dep_q)));
  end

  // Status decoded from the next state so every output leaves a flop.
  always_comb begin
    gate_l_d = 1'b0;
    gate_r_d = 1'b0;
    if (state_d == S_OPEN_IN) begin
      gate_l_d = (dir_d == DIR_UP);
      gate_r_d = (dir_d == DIR_DN);
    end else if (state_d == S_OPEN_OUT) begin
      gate_l_d = (dir_d == DIR_DN);
      gate_r_d = (dir_d == DIR_UP);
    end
    filling_d    = (state_d == S_FILL);
    draining_d   = (state_d == S_DRAIN);
    busy_d       = (state_d != S_IDLE);
    left_good_d  = (level_d == LVL_LO);
    right_good_d = (level_d == LVL_HI);
  end

  assign bus.level       = level_q;
  assign bus.gate_l_open = gate_l_q;
  assign bus.gate_r_open = gate_r_q;
  assign bus.filling     = filling_q;
  assign bus.draining    = draining_q;
  assign bus.in_chamber  = in_chamber_q;
  assign bus.left_good   = left_good_q;
  assign bus.right_good  = right_good_q;
  assign bus.pend_arr    = pend_arr_q;
  assign bus.pend_dep    = pend_dep_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_pound_lock_ctrl.sv
// Bench for pound_lock_ctrl: directed passages plus a long random run, every
// cycle compared against a phase/elapsed-time model of the lock.
module tb_pound_lock_ctrl;
  localparam int LEVEL_W = 8;
  localparam int LOW     = 0;
  localparam int HIGH    = 5;
  localparam int STEP    = 2;
  localparam int GATE    = 2;
  localparam int TO      = 10;

  localparam int P_IDLE   = 0;
  localparam int P_LEVEL  = 1;
  localparam int P_OPEN   = 2;
  localparam int P_SETTLE = 3;

  logic clk = 1'b0;
  logic reset;

  pound_lock_if #(.LEVEL_W(LEVEL_W)) bus ();

  pound_lock_ctrl #(
    .LEVEL_W(LEVEL_W), .LOW_LEVEL(LOW), .HIGH_LEVEL(HIGH),
    .STEP_CYCLES(STEP), .GATE_CYCLES(GATE), .OPEN_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase of the lock cycle, cycles spent in it, and the passage context.
  int m_phase, m_elapsed, m_level, m_start, m_target;
  bit m_up, m_exit, m_abort, m_boat, m_pa, m_pd, m_err;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_level = LOW; m_start = LOW; m_target = LOW;
    m_up = 0; m_exit = 0; m_abort = 0; m_boat = 0; m_pa = 0; m_pd = 0; m_err = 0;
  endtask

  task automatic start_level(input int target);
    m_phase = P_LEVEL; m_elapsed = 0; m_start = m_level; m_target = target;
  endtask

  task automatic model_step(input bit a, input bit d, input bit bp, input bit rn);
    bit open_now, clr_a, clr_d;
    if (!rn) begin
      model_reset();
      return;
    end
    open_now = (m_phase == P_OPEN);
    if ((bp && !open_now) || (open_now && ((a && m_pa) || (d && m_pd)))) m_err = 1;
    clr_a = 0; clr_d = 0;
    case (m_phase)
      P_IDLE: begin
        m_exit = 0; m_abort = 0;
        if ((m_pd || d) && m_level == HIGH) begin
          m_up = 0; m_phase = P_OPEN; m_elapsed = 0;
        end else if (m_pa || a) begin
          m_up = 1;
          if (m_level == LOW) begin m_phase = P_OPEN; m_elapsed = 0; end
          else start_level(LOW);
        end else if (m_pd || d) begin
          m_up = 0; start_level(HIGH);
        end
      end
      P_LEVEL: begin
        m_elapsed++;
        m_level = (m_target > m_start) ? m_start + m_elapsed / STEP : m_start - m_elapsed / STEP;
        if (m_level == m_target) begin m_phase = P_OPEN; m_elapsed = 0; end
      end
      P_OPEN: begin
        if (bp) begin
          if (m_exit) begin m_boat = 0; clr_a = m_up; clr_d = !m_up; end
          else m_boat = 1;
          m_phase = P_SETTLE; m_elapsed = 0;
        end else if (!m_exit && TO != 0) begin
          m_elapsed++;
          if (m_elapsed == TO) begin
            m_abort = 1; clr_a = m_up; clr_d = !m_up;
            m_phase = P_SETTLE; m_elapsed = 0;
          end
        end
      end
      default: begin
        m_elapsed++;
        if (m_elapsed == GATE) begin
          if (m_abort || m_exit) m_phase = P_IDLE;
          else begin m_exit = 1; start_level(m_up ? HIGH : LOW); end
        end
      end
    endcase
    m_pa = (m_pa && !clr_a) || a;
    m_pd = (m_pd && !clr_d) || d;
  endtask

  task automatic check_outputs();
    bit open_m;
    open_m = (m_phase == P_OPEN);
    check("level",       int'(bus.level),       m_level);
    check("gate_l_open", int'(bus.gate_l_open), int'(open_m && (m_up != m_exit)));
    check("gate_r_open", int'(bus.gate_r_open), int'(open_m && (m_up == m_exit)));
    check("filling",     int'(bus.filling),     int'(m_phase == P_LEVEL && m_target == HIGH));
    check("draining",    int'(bus.draining),    int'(m_phase == P_LEVEL && m_target == LOW));
    check("in_chamber",  int'(bus.in_chamber),  int'(m_boat));
    check("left_good",   int'(bus.left_good),   int'(m_level == LOW));
    check("right_good",  int'(bus.right_good),  int'(m_level == HIGH));
    check("pend_arr",    int'(bus.pend_arr),    int'(m_pa));
    check("pend_dep",    int'(bus.pend_dep),    int'(m_pd));
    check("busy",        int'(bus.busy),        int'(m_phase != P_IDLE));
    check("err",         int'(bus.err),         int'(m_err));
    check("ilk_two_gates",  int'(bus.gate_l_open && bus.gate_r_open), 0);
    check("ilk_left_level", int'(bus.gate_l_open && bus.level != LEVEL_W'(LOW)), 0);
    check("ilk_right_level", int'(bus.gate_r_open && bus.level != LEVEL_W'(HIGH)), 0);
    check("ilk_level_gate", int'((bus.filling || bus.draining) &&
                                 (bus.gate_l_open || bus.gate_r_open)), 0);
  endtask

  task automatic tick(input bit a, input bit d, input bit bp, input bit rn);
    bus.arrive_req = a; bus.depart_req = d; bus.boat_pass = bp; reset = rn;
    @(posedge clk);
    model_step(a, d, bp, rn);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_gate(input bit left, input int budget, output int n_fill, output int n_drain);
    bit seen;
    seen = 0; n_fill = 0; n_drain = 0;
    for (int i = 0; i < budget; i++) begin
      if ((left && bus.gate_l_open) || (!left && bus.gate_r_open)) begin
        seen = 1;
        break;
      end
      n_fill  += int'(bus.filling);
      n_drain += int'(bus.draining);
      tick(0, 0, 0, 1);
    end
    check(left ? "wait_gate_l" : "wait_gate_r", int'(seen), 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.busy; i++) tick(0, 0, 0, 1);
    check("wait_idle", int'(bus.busy), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int nf, nd, ng;
    model_reset();

    // Reset held for three cycles.
    repeat (3) tick(0, 0, 0, 0);
    check("rst_level", int'(bus.level), 0);
    check("rst_left_good", int'(bus.left_good), 1);
    check("rst_busy", int'(bus.busy), 0);

    // Upbound passage.
    tick(1, 0, 0, 1);
    check("up_gate_l", int'(bus.gate_l_open), 1);
    repeat (2) tick(0, 0, 0, 1);
    tick(0, 0, 1, 1);
    check("up_in_chamber", int'(bus.in_chamber), 1);
    wait_gate(0, 40, nf, nd);
    check("up_fill_cycles", nf, 10);
    check("up_level", int'(bus.level), 5);
    check("up_right_good", int'(bus.right_good), 1);
    tick(0, 0, 1, 1);
    check("up_out_chamber", int'(bus.in_chamber), 0);
    check("up_pend_clear", int'(bus.pend_arr), 0);
    repeat (2) tick(0, 0, 0, 1);
    check("up_done_busy", int'(bus.busy), 0);

    // Downbound starting from the low level.
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 1);
    check("dn_fill_now", int'(bus.filling), 1);
    wait_gate(0, 40, nf, nd);
    check("dn_fill_cycles", nf, 10);
    tick(0, 0, 1, 1);
    wait_gate(1, 40, nf, nd);
    check("dn_drain_cycles", nd, 10);
    check("dn_level", int'(bus.level), 0);
    tick(0, 0, 1, 1);
    repeat (2) tick(0, 0, 0, 1);
    check("dn_done_busy", int'(bus.busy), 0);

    // Raise the chamber by letting a downbound entry time out.
    tick(0, 1, 0, 1);
    wait_gate(0, 40, nf, nd);
    wait_idle(30);
    check("hi_level", int'(bus.level), 5);

    // Both requests at the high level: downbound served first.
    tick(1, 1, 0, 1);
    check("sim_gate_r", int'(bus.gate_r_open), 1);
    check("sim_pend_arr", int'(bus.pend_arr), 1);
    tick(0, 0, 1, 1);
    wait_gate(1, 40, nf, nd);
    tick(0, 0, 1, 1);
    repeat (2) tick(0, 0, 0, 1);
    check("sim_idle", int'(bus.busy), 0);
    tick(0, 0, 0, 1);
    check("sim_up_next", int'(bus.gate_l_open), 1);

    // Let that upbound entry time out.
    ng = 0;
    for (int i = 0; i < 30 && bus.gate_l_open; i++) begin
      ng++;
      tick(0, 0, 0, 1);
    end
    check("to_open_cycles", ng, 10);
    check("to_pend_clear", int'(bus.pend_arr), 0);
    repeat (2) tick(0, 0, 0, 1);
    check("to_idle", int'(bus.busy), 0);
    check("to_level", int'(bus.level), 0);

    // Reset in the middle of a fill.
    tick(0, 1, 0, 1);
    for (int i = 0; i < 20 && bus.level != LEVEL_W'(3); i++) tick(0, 0, 0, 1);
    check("mid_level3", int'(bus.level), 3);
    tick(0, 0, 0, 0);
    check("mid_rst_level", int'(bus.level), 0);
    check("mid_rst_busy", int'(bus.busy), 0);

    // Stray boat_pass sets a sticky error.
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 1);
    check("err_set", int'(bus.err), 1);
    repeat (3) tick(0, 0, 0, 1);
    check("err_sticky", int'(bus.err), 1);
    tick(0, 0, 0, 0);
    check("err_cleared", int'(bus.err), 0);

    // Random traffic.
    for (int i = 0; i < 5000; i++) begin
      tick($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 12, $urandom_range(0, 499) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pound_lock_ctrl.md
Name: pound_lock_ctrl

Overview:
- Parametrised, self-sequencing controller for a single canal pound lock chamber, replacing hand-driven fill/drain control.
- Left water sits at LOW_LEVEL (downstream) and right water at HIGH_LEVEL (upstream).
- Queues upbound and downbound passage requests, models the chamber water level with a step counter, and interlocks the gates against the level.
- Applies a gate-settle delay and an entry timeout. Sits under the board top level, fed by debounced switch/key inputs; outputs drive LEDR.

Parameters:
- LEVEL_W, 8, width of the level register.
- LOW_LEVEL, 0, chamber level that matches left water.
- HIGH_LEVEL, 100, chamber level that matches right water. Must satisfy LOW_LEVEL < HIGH_LEVEL < 2**LEVEL_W.
- STEP_CYCLES, 4, clock cycles per one-unit level change while filling or draining (>=1).
- GATE_CYCLES, 2, number of settle cycles spent in a CLOSE state after a gate shuts (>=1).
- OPEN_TIMEOUT, 16, cycles an entry gate stays open waiting for a boat. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- arrive_req  in  1  boat at left requests upbound passage (level held or pulsed).
- depart_req  in  1  boat at right requests downbound passage (level held or pulsed).
- boat_pass  in  1  one-cycle pulse: boat crossed the currently open gate.
- level  out  LEVEL_W  current chamber level.
- gate_l_open  out  1  left gate open.
- gate_r_open  out  1  right gate open.
- filling  out  1  FILL state active.
- draining  out  1  DRAIN state active.
- in_chamber  out  1  boat inside chamber.
- left_good  out  1  level==LOW_LEVEL.
- right_good  out  1  level==HIGH_LEVEL.
- pend_arr  out  1  latched upbound request.
- pend_dep  out  1  latched downbound request.
- busy  out  1  state != IDLE.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - state IDLE, level=LOW_LEVEL, step and timer counters 0.
  - All outputs 0 except left_good=1.
  - Reset mid-operation aborts immediately; nothing is preserved.
- Request latching:
  - arrive_req=1 on an edge sets pend_arr; depart_req=1 sets pend_dep.
  - Each flag clears only when its passage completes or times out.
  - Requests arriving while busy are queued.
- FSM states: IDLE, DRAIN, FILL, OPEN_IN, CLOSE_IN, OPEN_OUT, CLOSE_OUT. A direction register dir records the passage direction (UP = arrive, DN = depart).
- IDLE selection, evaluated on each edge with the just-sampled requests included:
  - Serve the request whose entry side matches the current level: UP needs LOW_LEVEL, DN needs HIGH_LEVEL.
  - Otherwise UP wins.
  - If the level does not match the chosen entry side, go to DRAIN (UP) or FILL (DN); else go to OPEN_IN.
  - Latency: a request in IDLE at a matching level opens the gate on the next edge.
- Leveling:
  - FILL/DRAIN increment/decrement level by 1 every STEP_CYCLES cycles, starting STEP_CYCLES cycles after entry.
  - level never passes HIGH_LEVEL or LOW_LEVEL.
  - The edge that writes the target level also leaves FILL/DRAIN, so gate open and right_good/left_good rise together.
  - In a passage, after CLOSE_IN go to FILL (UP) or DRAIN (DN), then to OPEN_OUT.
- OPEN_IN:
  - Opens the entry gate (left for UP, right for DN).
  - boat_pass: gate closes on that edge, in_chamber=1, go to CLOSE_IN.
  - Timeout: OPEN_TIMEOUT cycles with no boat_pass closes the gate, clears that pend flag, and goes to CLOSE_IN with an abort mark; after settle, return to IDLE without leveling.
- CLOSE_IN / CLOSE_OUT: all gates closed for exactly GATE_CYCLES cycles.
- OPEN_OUT:
  - Opens the exit gate; no timeout.
  - boat_pass: gate closes, in_chamber=0, clear the pend flag, go to CLOSE_OUT, then IDLE.
- Interlocks (invariants the bench checks every cycle):
  - gate_l_open and gate_r_open are never both 1.
  - A gate is open only when level equals its side's level.
  - filling/draining are never 1 with any gate open.
- Errors: err is set by boat_pass outside OPEN_IN/OPEN_OUT, or by a request input held during an open state for a direction already pending. err is cleared only by reset.
- Simultaneous events:
  - boat_pass and a timeout on the same edge: boat_pass wins.
  - A new request on the completion edge is latched and served from IDLE on the next edge.

Test Plan:
- Params for all scenarios: HIGH_LEVEL=5, LOW_LEVEL=0, STEP_CYCLES=2, GATE_CYCLES=2, OPEN_TIMEOUT=10.
- Reset: hold reset=0 for 3 cycles -> level=0, left_good=1, every other output 0; assert reset=0 mid-FILL at level=3 -> next edge level=0, state IDLE.
- Upbound pass: arrive_req pulse -> gate_l_open=1 next edge; boat_pass -> in_chamber=1, gates closed 2 cycles, filling=1 for 10 cycles, level 0->5, gate_r_open rises with right_good; boat_pass -> in_chamber=0, pend_arr=0, busy=0 after 2 more cycles.
- Downbound from low level: depart_req at level=0 -> filling immediately, 10 cycles to level=5, then gate_r_open; full passage drains 5->0 and ends with gate_l_open until boat_pass.
- Simultaneous arrive_req+depart_req at level=5 -> DN served first (matching level), pend_arr stays 1; after DN completes, UP starts next edge with gate_l_open.
- Timeout: arrive_req, no boat_pass -> gate_l_open for exactly 10 cycles, then closed, pend_arr=0, idle after 2 settle cycles, level unchanged at 0.
- Error and interlock: boat_pass in IDLE -> err=1 and stays 1 until reset; random stimulus run of 5000 cycles -> interlock assertions never fire.
